operand_scoreboard: RTL

Issue-stage hazard controller for the pipelined core. It tracks destination registers of in-flight long-latency instructions (loads, M-extension mul/div, CSR reads) and gates issue of any decoded instruction whose sources or destination collide with them. It sits between the instruction decoder outputs and the execute issue point, and is cleared by writeback.

---
 rtl/operand_scoreboard_pkg.sv | 24 ++
 rtl/operand_scoreboard.sv | 99 +++++++++
 2 files changed

// File: rtl/operand_scoreboard_pkg.sv
// Shared constants, hazard record and index helpers for the issue-stage operand scoreboard.
package operand_scoreboard_pkg;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam int SCOREBOARD_MAX_PENDING = 4;

   // Register indices are always 5 bits wide, even for RV32E.
   localparam int IDX_W     = 5;
   localparam int IDX_SPACE = 1 << IDX_W;

   typedef struct packed {
      logic raw1;
      logic raw2;
      logic waw;
      logic cap;
   } hazard_t;

   function automatic logic idx_in_range(input logic [IDX_W-1:0] idx, input int reg_count);
      return int'(idx) < reg_count;
   endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// Issue-stage hazard controller: tracks destinations of in-flight long-latency ops and
// gates issue of instructions that read or overwrite them until writeback clears them.
module operand_scoreboard
   import operand_scoreboard_pkg::*;
#(
   parameter int REG_COUNT   = 32,
   parameter int MAX_PENDING = SCOREBOARD_MAX_PENDING,
   parameter bit WB_BYPASS   = ENABLE,
   localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 issue_valid,
   input  logic                 issue_long,
   input  logic [IDX_W-1:0]     read_index_1,
   input  logic [IDX_W-1:0]     read_index_2,
   input  logic                 read_enable_1,
   input  logic                 read_enable_2,
   input  logic [IDX_W-1:0]     write_index,
   input  logic                 write_enable,
   output logic                 issue_ready,
   output logic                 stall,
   input  logic                 writeback_valid,
   input  logic [IDX_W-1:0]     writeback_index,
   output logic [REG_COUNT-1:0] pending_mask,
   output logic [CNT_W-1:0]     pending_count,
   output logic                 error
);

   logic [REG_COUNT-1:0] mask_q, mask_d;
   logic [CNT_W-1:0]     count_q, count_d, eff_count;
   logic                 error_q, error_d;
   logic [IDX_SPACE-1:0] mask_ext, clr_vec, set_vec, eff_ext, next_ext;
   logic                 clr_ev, set_elig, set_ev, accept, range_err;
   hazard_t              hz;

   always_comb begin
      // Widen to the full 5-bit index space so out-of-range indices read as not pending.
      mask_ext                = '0;
      mask_ext[REG_COUNT-1:0] = mask_q;

      clr_ev                   = writeback_valid & mask_ext[writeback_index];
      clr_vec                  = '0;
      clr_vec[writeback_index] = clr_ev;

      eff_ext   = WB_BYPASS ? (mask_ext & ~clr_vec) : mask_ext;
      eff_count = (WB_BYPASS && clr_ev) ? count_q - CNT_W'(1) : count_q;

      set_elig = issue_long & write_enable & (write_index != '0)
               & idx_in_range(write_index, REG_COUNT);

      hz.raw1 = read_enable_1 & eff_ext[read_index_1];
      hz.raw2 = read_enable_2 & eff_ext[read_index_2];
      hz.waw  = write_enable & eff_ext[write_index];
      hz.cap  = set_elig & (eff_count == CNT_W'(MAX_PENDING));

      issue_ready = ~|hz;
      accept      = issue_valid & issue_ready;
      set_ev      = accept & set_elig;

      set_vec              = '0;
      set_vec[write_index] = set_ev;

      // Set wins over a same-index clear, leaving the bit pending and the count unchanged.
      next_ext = (mask_ext & ~clr_vec) | set_vec;
      mask_d   = next_ext[REG_COUNT-1:0];

      count_d = count_q;
      if (set_ev && !clr_ev) begin
         count_d = count_q + CNT_W'(1);
      end else if (clr_ev && !set_ev) begin
         count_d = count_q - CNT_W'(1);
      end

      range_err = accept & ((read_enable_1 & ~idx_in_range(read_index_1, REG_COUNT))
                          | (read_enable_2 & ~idx_in_range(read_index_2, REG_COUNT))
                          | (write_enable  & ~idx_in_range(write_index,  REG_COUNT)));

      error_d = error_q | (writeback_valid & ~clr_ev) | range_err;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q  <= '0;
         count_q <= '0;
         error_q <= DISABLE;
      end else begin
         mask_q  <= mask_d;
         count_q <= count_d;
         error_q <= error_d;
      end
   end

   assign stall         = issue_valid & ~issue_ready;
   assign pending_mask  = mask_q;
   assign pending_count = count_q;
   assign error         = error_q;

endmodule
